// File: rtl/ex_alu_stage.sv
// ex_alu_stage: ALU execute stage feeding an EX/MEM register with valid/ready handshake, stall and flush.
// Define EX_SKID_BUF_EN to add a one-entry skid buffer so in_ready comes straight from a flop.
module ex_alu_stage #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctl,
  input  logic            is_branch,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [RD_W-1:0] rd_in,
  input  logic            wen_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            br_taken,
  output logic [RD_W-1:0] rd_out,
  output logic            wen_out
);
  localparam int W = XLEN + RD_W + 2;
  logic [XLEN-1:0] res;
  logic [4:0]      sh;
  logic [W-1:0]    in_pkt, out_q, out_d;
  logic            valid_q, valid_d, accept;
  assign sh = op_b[4:0];
  always_comb begin
    res = '0;
    case (alu_ctl)
      4'b0000: res = op_a + op_b;
      4'b0001: res = op_a - op_b;
      4'b0010: res = op_a << sh;
      4'b0011: res = op_a >> sh;
      4'b1000: res = $signed(op_a) >>> sh;
      4'b0100: res[0] = op_a < op_b;
      4'b1001: res[0] = $signed(op_a) < $signed(op_b);
      4'b0101: res = op_a & op_b;
      4'b0110: res = op_a | op_b;
      4'b0111: res = op_a ^ op_b;
      4'b1011: res = op_b;
      4'b1100: res[0] = op_a == op_b;
      4'b1101: res[0] = op_a != op_b;
      4'b1110: res[0] = $signed(op_a) >= $signed(op_b);
      4'b1111: res[0] = op_a >= op_b;
      default: res = '0;
    endcase
  end
  // Branches never write the register file.
  assign in_pkt = {res, is_branch & res[0], rd_in, wen_in & ~is_branch};
  assign {result, br_taken, rd_out, wen_out} = out_q;
  assign out_valid = valid_q;
`ifdef EX_SKID_BUF_EN
  logic         skid_vq, skid_vd, adv;
  logic [W-1:0] skid_q, skid_d;
  assign in_ready = ~skid_vq;
  assign accept = in_valid & ~skid_vq;
  assign adv = ~valid_q | out_ready;
  always_comb begin
    valid_d = flush ? 1'b0 : adv ? (skid_vq | accept) : 1'b1;
    out_d = (adv & skid_vq) ? skid_q : (adv & accept) ? in_pkt : out_q;
    skid_vd = ~flush & ~adv & (skid_vq | accept);
    skid_d = (~adv & accept) ? in_pkt : skid_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      skid_vq <= 1'b0;
      skid_q <= '0;
    end else begin
      skid_vq <= skid_vd;
      skid_q <= skid_d;
    end
`else
  assign in_ready = ~valid_q | out_ready;
  assign accept = in_valid & in_ready;
  assign valid_d = ~flush & (accept | (valid_q & ~out_ready));
  assign out_d = accept ? in_pkt : out_q;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      out_q <= '0;
    end else begin
      valid_q <= valid_d;
      out_q <= out_d;
    end
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: randomized and directed checks of ex_alu_stage against a behavioural ALU/queue model.
module tb_ex_alu_stage;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_ready, is_branch = 0, wen_in = 0, flush = 0;
  logic        out_valid, out_ready = 1, br_taken, wen_out;
  logic [3:0]  alu_ctl = 0;
  logic [31:0] op_a = 0, op_b = 0, result;
  logic [4:0]  rd_in = 0, rd_out;
  int chk = 0, fails = 0;

  ex_alu_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .alu_ctl(alu_ctl),
    .is_branch(is_branch), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .wen_in(wen_in),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .br_taken(br_taken), .rd_out(rd_out), .wen_out(wen_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint sa, sb;
    logic [63:0] ext;
    sh = b % 32;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    ext = {{32{a[31]}}, a};
    case (c)
      4'd0: return a + b;
      4'd1: return a + ~b + 1;
      4'd2: return a * (33'd1 << sh);
      4'd3: return a / (33'd1 << sh);
      4'd8: return 32'(ext >> sh);
      4'd4: return {31'd0, {1'b0, a} < {1'b0, b}};
      4'd9: return {31'd0, sa < sb};
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd11: return b;
      4'd12: return {31'd0, a == b};
      4'd13: return {31'd0, a != b};
      4'd14: return {31'd0, sa >= sb};
      4'd15: return {31'd0, {1'b0, a} >= {1'b0, b}};
      default: return 32'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic br, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic w);
    in_valid = v; alu_ctl = c; is_branch = br; op_a = a; op_b = b; rd_in = rd; wen_in = w;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    chk++;
    if ({out_valid, result, br_taken, rd_out, wen_out} !== 40'd0) begin
      fails++; $display("FAIL reset outputs got=%h exp=0", {out_valid, result, br_taken, rd_out, wen_out});
    end
    chk++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got=%b exp=1", in_ready); end
    step();
    rst_n = 1;
    step();
  endtask

  task automatic test_add();
    drive(1, 4'b0000, 0, 5, 7, 3, 1);
    step();
    in_valid = 0;
    chk++;
    if ({out_valid, result, rd_out, wen_out, br_taken} !== {1'b1, 32'd12, 5'd3, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add got v=%b r=%h rd=%0d w=%b bt=%b exp v=1 r=c rd=3 w=1 bt=0",
                        out_valid, result, rd_out, wen_out, br_taken);
    end
    step();
    chk++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_alu_codes();
    logic [3:0]  c;
    logic [31:0] a, b, e;
    logic        br, w;
    logic [4:0]  rd;
    logic [3:0]  dc [9] = '{4'b0001, 4'b1000, 4'b0011, 4'b1010, 4'b1011, 4'b1001, 4'b0100, 4'b1111, 4'b0010};
    logic [31:0] da [9] = '{0, 32'h80000000, 32'h80000000, 32'h1234, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 9, 32'h1};
    logic [31:0] db [9] = '{1, 4, 4, 32'h55, 32'hABCD0000, 1, 1, 9, 31};
    logic [31:0] dx [9] = '{32'hFFFFFFFF, 32'hF8000000, 32'h08000000, 0, 32'hABCD0000, 1, 0, 1, 32'h80000000};
    for (int i = 0; i < 9 + 60; i++) begin
      if (i < 9) begin
        c = dc[i]; a = da[i]; b = db[i]; br = (i >= 5 && i <= 7); w = 1; rd = 5'(i);
      end else begin
        c = 4'($urandom_range(15)); a = $urandom; b = ($urandom_range(3) == 0) ? a : $urandom;
        br = 1'($urandom); w = 1'($urandom); rd = 5'($urandom);
      end
      e = alu_ref(c, a, b);
      chk++;
      if (i < 9 && e !== dx[i]) begin
        fails++; $display("FAIL ref_vector %0d ref=%h exp=%h", i, e, dx[i]);
      end
      drive(1, c, br, a, b, rd, w);
      step();
      chk++;
      if ({out_valid, result, br_taken, rd_out, wen_out} !== {1'b1, e, br & e[0], rd, w & ~br}) begin
        fails++; $display("FAIL alu ctl=%b a=%h b=%h got v=%b r=%h bt=%b rd=%0d w=%b exp r=%h bt=%b rd=%0d w=%b",
                          c, a, b, out_valid, result, br_taken, rd_out, wen_out, e, br & e[0], rd, w & ~br);
      end
    end
    in_valid = 0;
    step();
  endtask

  task automatic test_stall();
    drive(1, 4'b0000, 0, 1, 2, 4, 1);
    step();
    drive(1, 4'b0111, 0, 32'hF0F0, 32'h0FF0, 6, 1);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk++;
      if ({out_valid, result, rd_out, wen_out} !== {1'b1, 32'd3, 5'd4, 1'b1}) begin
        fails++; $display("FAIL stall_hold cyc=%0d got v=%b r=%h rd=%0d exp v=1 r=3 rd=4", i, out_valid, result, rd_out);
      end
`ifndef EX_SKID_BUF_EN
      chk++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
`endif
    end
    out_ready = 1;
    step();
    in_valid = 0;
    chk++;
    if ({out_valid, result, rd_out} !== {1'b1, 32'h0000FF00, 5'd6}) begin
      fails++; $display("FAIL stall_release got v=%b r=%h rd=%0d exp v=1 r=ff00 rd=6", out_valid, result, rd_out);
    end
    step();
    chk++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_drain out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    drive(1, 4'b0000, 0, 10, 20, 7, 1);
    step();
    drive(1, 4'b0110, 0, 32'h0F, 32'hF0, 9, 1);
    flush = 1;
    chk++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    step();
    flush = 0;
    in_valid = 0;
    chk++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush out_valid got=%b exp=0", out_valid); end
    step();
    chk++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_dropped out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    drive(1, 4'b1011, 1, 0, 32'hFFFFFFFF, 31, 1);
    step();
    in_valid = 0;
    #2;
    rst_n = 0;
    #1;
    chk++;
    if ({out_valid, result, br_taken, rd_out, wen_out} !== 40'd0) begin
      fails++; $display("FAIL async_reset got=%h exp=0", {out_valid, result, br_taken, rd_out, wen_out});
    end
    step();
    rst_n = 1;
    step();
    chk++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] q[$];
    logic [39:0] got;
    logic [31:0] e;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(9) < 7), 4'($urandom_range(15)), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
      if ($urandom_range(3) == 0) op_b = op_a;
      out_ready = ($urandom_range(9) < 6);
      flush = ($urandom_range(19) == 0);
      #3;
      chk++;
      if (out_valid !== (q.size() != 0)) begin
        fails++; $display("FAIL b2b_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() != 0);
      end
`ifdef EX_SKID_BUF_EN
      chk++;
      if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
`else
      chk++;
      if (in_ready !== (q.size() == 0 || out_ready)) begin
        fails++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() == 0 || out_ready);
      end
`endif
      got = {result, br_taken, rd_out, wen_out};
      if (out_valid && q.size() != 0) begin
        chk++;
        if (got !== q[0]) begin fails++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, got, q[0]); end
      end
      if (flush) q.delete();
      else begin
        if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
        if (in_valid && in_ready) begin
          e = alu_ref(alu_ctl, op_a, op_b);
          q.push_back({e, is_branch & e[0], rd_in, wen_in & ~is_branch});
        end
      end
      step();
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_codes();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule
